gray_code_counter: RTL and testbench
====================================

// Module: gray_code_counter
// PURPOSE
//  Parametrised up/down counter holding state as binary, presenting registered
//  Gray and binary outputs. Source of glitch-free multi-bit pointers/timestamps
//  that cross clock domains (FIFO read/write pointers, event counters).
//  Gray output changes exactly one bit per count step, so it is safe to sample
//  with a 2-flop synchroniser.
// PARAMETERS
//  WIDTH     4   counter/code width in bits (>= 2)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  en        in   1      count enable; one step per cycle while high
//  up_dn     in   1      1 = count up, 0 = count down
//  load      in   1      synchronous load of load_bin
//  load_bin  in   WIDTH  binary value to load
//  bin_out   out  WIDTH  registered binary count
//  gray_out  out  WIDTH  registered Gray code of bin_out
//  wrap      out  1      one-cycle pulse: count wrapped (or saturated, see CONFIG)
// BEHAVIOUR
//  - Reset (rst_n low, async): bin_out=0, gray_out=0, wrap=0; held while low.
//    Release is synchronous to clk; first count on the first edge with en=1.
//  - Priority per edge: load > en > hold.
//  - load=1: bin_out<=load_bin, gray_out<=bin2gray(load_bin), wrap<=0.
//    Latency 1 cycle. Gray output may change >1 bit on a load (documented;
//    consumers must not rely on single-bit change across loads).
//  - en=1, load=0: bin_next = bin_out +1 (up_dn=1) or -1 (up_dn=0), modulo
//    2**WIDTH. gray_out<=bin2gray(bin_next) in the same edge; gray_out always
//    equals bin2gray(bin_out) -- no cycle of skew between the two outputs.
//  - bin2gray: g = b ^ (b >> 1). gray2bin: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
//  - wrap: asserted for the one cycle after an edge where up from all-ones to 0
//    or down from 0 to all-ones occurred; 0 otherwise (incl. hold and load).
//  - en=0, load=0: all outputs hold; wrap<=0.
//  - up_dn may change any cycle; direction applies to the edge it is sampled on.
//  - Reset asserted mid-count: immediate return to reset values, no wrap pulse.
//  - gray_out is driven straight from flops (no combinational logic after the
//    register) so it is CDC-safe.
// CONFIGURATION
//  GRAY_CNT_SAT_EN defined: counter saturates instead of wrapping. Up at
//    all-ones or down at 0 holds the value; wrap then pulses for one cycle on
//    each such blocked step (acts as saturation flag). load still unrestricted.
//  GRAY_CNT_SAT_EN undefined: modulo counting as above; wrap = wrap-around pulse.
// STRUCTURE
//  - Package gray_code_pkg: functions bin2gray(), gray2bin() parametrised on
//    WIDTH; localparam-style constants CNT_MAX (all-ones) and CNT_MIN (0).
//  - Sub-module gray_to_bin_dec (combinational, WIDTH-param, uses gray2bin):
//    instantiated by receive-side logic and by the bench checker; not needed
//    inside the counter datapath (binary is the stored state).
//  - Counter: one binary register, one Gray register, one wrap flop.
// TESTING (WIDTH=4 unless noted)
//  1 Reset: rst_n=0 mid-stream -> bin_out=0, gray_out=0000, wrap=0 immediately,
//    before next clk edge.
//  2 Up count, en=1, up_dn=1, 16 cycles from 0 -> gray 0000,0001,0011,0010,0110,
//    ...,1000 (bin 15); next edge bin 0, gray 0000, wrap=1 for exactly one cycle.
//  3 Down from 0: en=1, up_dn=0 -> bin 15, gray 1000, wrap=1; next edge bin 14,
//    gray 1001, wrap=0.
//  4 load=1, load_bin=1010 with en=1 -> next cycle bin 1010, gray 1111, wrap=0
//    (load beats en); then one up step -> bin 1011, gray 1110.
//  5 Every count edge (random en/up_dn, 1000 cycles, WIDTH=4 and 8): popcount
//    of gray_out change == 1 and gray_to_bin_dec(gray_out)==bin_out every cycle.
//  6 GRAY_CNT_SAT_EN: up from 14 for 3 cycles -> bin 15,15,15; wrap 0,1,1;
//    down from 0 -> bin stays 0, wrap=1.

Source files
------------

// File: rtl/gray_code_pkg.sv
// ============================================================================
// Module      : gray_code_pkg
// Description : Shared Gray/binary conversion helpers, step decode type and
//               counter range constants for the Gray code counter family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_code_pkg;

    // Widest counter the helpers support; narrower callers zero-extend in
    // and truncate out, which is exact for both conversions.
    localparam int GRAY_MAX_WIDTH = 64;

    localparam logic [GRAY_MAX_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [GRAY_MAX_WIDTH-1:0] CNT_MIN = '0;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_LOAD = 2'd1,
        STEP_UP   = 2'd2,
        STEP_DOWN = 2'd3
    } step_e;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] g
    );
        logic [GRAY_MAX_WIDTH-1:0] b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_to_bin_dec.sv
// ============================================================================
// Module      : gray_to_bin_dec
// Description : Combinational Gray-to-binary decoder for receive-side logic
//               that samples a synchronised Gray count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_to_bin_dec
    import gray_code_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [GRAY_MAX_WIDTH-1:0] w_gray_ext;
    logic [GRAY_MAX_WIDTH-1:0] w_bin_ext;

    assign w_gray_ext = GRAY_MAX_WIDTH'(gray);
    assign w_bin_ext  = gray2bin(w_gray_ext);
    assign bin        = w_bin_ext[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/gray_code_counter.sv
// ============================================================================
// Module      : gray_code_counter
// Description : Up/down counter with registered binary and Gray outputs and a
//               wrap pulse. Define GRAY_CNT_SAT_EN to saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_code_counter
    import gray_code_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_CNT_MAX = CNT_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_CNT_MIN = CNT_MIN[WIDTH-1:0];

    logic [WIDTH-1:0]          r_bin;
    logic [WIDTH-1:0]          r_gray;
    logic                      r_wrap;

    step_e                     w_step;
    logic                      w_at_max;
    logic                      w_at_min;
    logic [WIDTH-1:0]          w_bin_next;
    logic                      w_wrap_next;
    logic [GRAY_MAX_WIDTH-1:0] w_gray_next_ext;

    assign w_at_max = (r_bin == C_CNT_MAX);
    assign w_at_min = (r_bin == C_CNT_MIN);

    always_comb begin
        w_step = STEP_HOLD;
        if (load) begin
            w_step = STEP_LOAD;
        end else if (en) begin
            w_step = up_dn ? STEP_UP : STEP_DOWN;
        end
    end

    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        case (w_step)
            STEP_LOAD: begin
                w_bin_next = load_bin;
            end
            STEP_UP: begin
`ifdef GRAY_CNT_SAT_EN
                if (w_at_max) begin
                    w_wrap_next = 1'b1;
                end else begin
                    w_bin_next = r_bin + C_ONE;
                end
`else
                w_bin_next  = r_bin + C_ONE;
                w_wrap_next = w_at_max;
`endif
            end
            STEP_DOWN: begin
`ifdef GRAY_CNT_SAT_EN
                if (w_at_min) begin
                    w_wrap_next = 1'b1;
                end else begin
                    w_bin_next = r_bin - C_ONE;
                end
`else
                w_bin_next  = r_bin - C_ONE;
                w_wrap_next = w_at_min;
`endif
            end
            default: begin
                w_bin_next  = r_bin;
                w_wrap_next = 1'b0;
            end
        endcase
    end

    // Gray is encoded from the next binary value so both registers update on
    // the same edge and never disagree.
    assign w_gray_next_ext = bin2gray(GRAY_MAX_WIDTH'(w_bin_next));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next_ext[WIDTH-1:0];
            r_wrap <= w_wrap_next;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_gray_code_counter.sv
// ============================================================================
// Module      : tb_gray_code_counter
// Description : Self-checking bench for gray_code_counter (WIDTH 4 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_code_counter;

    typedef struct packed {
        logic       load;
        logic       en;
        logic       up_dn;
        logic [3:0] load_bin;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        logic       exp_wrap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_bin;
    logic [7:0] load_bin8;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic       wrap;
    logic [7:0] bin8;
    logic [7:0] gray8;
    logic       wrap8;
    logic [3:0] dec4;
    logic [7:0] dec8;

    int checks   = 0;
    int failures = 0;

    vec_t       vecs[21];
    logic [3:0] gtab[16];

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
    );

    gray_code_counter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin8), .bin_out(bin8), .gray_out(gray8), .wrap(wrap8)
    );

    gray_to_bin_dec #(.WIDTH(4)) u_dec4 (.gray(gray_out), .bin(dec4));
    gray_to_bin_dec #(.WIDTH(8)) u_dec8 (.gray(gray8), .bin(dec8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic e, input logic u,
                                input logic [3:0] lb, input logic [3:0] b,
                                input logic [3:0] g, input logic w);
        return vec_t'({ld, e, u, lb, b, g, w});
    endfunction

    // Reference step model: returns the next count; sets wrp on a wrap/saturate event.
    function automatic int model_step(input int m, input int maxv, input logic e,
                                      input logic u, output logic wrp);
        int n;
        n   = m;
        wrp = 1'b0;
        if (e) begin
            if (u) begin
                wrp = (m == maxv);
`ifdef GRAY_CNT_SAT_EN
                if (m != maxv) n = m + 1;
`else
                n = (m == maxv) ? 0 : m + 1;
`endif
            end else begin
                wrp = (m == 0);
`ifdef GRAY_CNT_SAT_EN
                if (m != 0) n = m - 1;
`else
                n = (m == 0) ? maxv : m - 1;
`endif
            end
        end
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   m4;
        int   m8;
        int   n4;
        int   n8;
        logic w4;
        logic w8;
        logic [3:0] p4;
        logic [7:0] p8;
        logic [3:0] e4;
        logic [7:0] e8;

        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        //               ld    en    up    lbin     bin      gray     wrap
        vecs[0]  = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd1,  4'b0001, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd2,  4'b0011, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 4'd0,  4'd2,  4'b0011, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd1,  4'b0001, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0);
`ifdef GRAY_CNT_SAT_EN
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0);
`else
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd15, 4'b1000, 1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd14, 4'b1001, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  4'd14, 4'b1001, 1'b0);
`endif
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 4'd10, 4'd10, 4'b1111, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd11, 4'b1110, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd12, 4'b1010, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd13, 4'b1011, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd14, 4'b1001, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd15, 4'b1000, 1'b0);
`ifdef GRAY_CNT_SAT_EN
        vecs[14] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd15, 4'b1000, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 4'd0,  4'd15, 4'b1000, 1'b0);
`else
        vecs[14] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'b0000, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  4'b0000, 1'b0);
`endif
        vecs[16] = mk(1'b1, 1'b0, 1'b1, 4'd15, 4'd15, 4'b1000, 1'b0);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0);
`ifdef GRAY_CNT_SAT_EN
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b1);
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd1,  4'b0001, 1'b0);
`else
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 4'd0,  4'd15, 4'b1000, 1'b1);
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'b0000, 1'b1);
`endif
        vecs[20] = mk(1'b1, 1'b0, 1'b1, 4'd5,  4'd5,  4'b0111, 1'b0);

        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_bin = 4'd0; load_bin8 = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_bin",  32'(bin_out),  32'd0);
        check("reset_gray", 32'(gray_out), 32'd0);
        check("reset_wrap", 32'(wrap),     32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            load = vecs[i].load; en = vecs[i].en; up_dn = vecs[i].up_dn;
            load_bin = vecs[i].load_bin;
            @(negedge clk);
            check($sformatf("vec%0d_bin", i),  32'(bin_out),  32'(vecs[i].exp_bin));
            check($sformatf("vec%0d_gray", i), 32'(gray_out), 32'(vecs[i].exp_gray));
            check($sformatf("vec%0d_wrap", i), 32'(wrap),     32'(vecs[i].exp_wrap));
        end

        // Full up sweep from 0 through the top of the range.
        load = 1'b1; load_bin = 4'd0; en = 1'b0;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
`ifdef GRAY_CNT_SAT_EN
            e4 = (k > 15) ? 4'd15 : 4'(k);
`else
            e4 = 4'(k % 16);
`endif
            check($sformatf("sweep%0d_bin", k),  32'(bin_out),  32'(e4));
            check($sformatf("sweep%0d_gray", k), 32'(gray_out), 32'(gtab[e4]));
            check($sformatf("sweep%0d_wrap", k), 32'(wrap),     (k == 16) ? 32'd1 : 32'd0);
        end
        en = 1'b0;
        @(negedge clk);
        check("sweep_wrap_one_cycle", 32'(wrap), 32'd0);

`ifdef GRAY_CNT_SAT_EN
        load = 1'b1; load_bin = 4'd14;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("sat_up%0d_bin", k),  32'(bin_out), 32'd15);
            check($sformatf("sat_up%0d_wrap", k), 32'(wrap),    (k == 0) ? 32'd0 : 32'd1);
        end
        load = 1'b1; load_bin = 4'd0; en = 1'b0;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        @(negedge clk);
        check("sat_dn_bin",  32'(bin_out), 32'd0);
        check("sat_dn_wrap", 32'(wrap),    32'd1);
        en = 1'b0;
`endif

        // Asynchronous reset in the middle of a count.
        load = 1'b1; load_bin = 4'd9; en = 1'b0;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bin",  32'(bin_out),  32'd0);
        check("async_rst_gray", 32'(gray_out), 32'd0);
        check("async_rst_wrap", 32'(wrap),     32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_held_bin", 32'(bin_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_bin",  32'(bin_out),  32'd1);
        check("rst_release_gray", 32'(gray_out), 32'b0001);

        // Random en/up_dn on both widths against the reference model.
        en = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m4 = 0; m8 = 0;
        for (int c = 0; c < 1000; c++) begin
            en    = 1'($urandom_range(0, 1));
            up_dn = 1'($urandom_range(0, 1));
            p4 = gray_out; p8 = gray8;
            n4 = model_step(m4, 15, en, up_dn, w4);
            n8 = model_step(m8, 255, en, up_dn, w8);
            @(negedge clk);
            e4 = 4'(n4); e8 = 8'(n8);
            check("rnd4_bin",  32'(bin_out),  32'(e4));
            check("rnd4_gray", 32'(gray_out), 32'(e4 ^ (e4 >> 1)));
            check("rnd4_wrap", 32'(wrap),     32'(w4));
            check("rnd4_dec",  32'(dec4),     32'(bin_out));
            check("rnd4_onebit", 32'($countones(p4 ^ gray_out)), (n4 != m4) ? 32'd1 : 32'd0);
            check("rnd8_bin",  32'(bin8),  32'(e8));
            check("rnd8_gray", 32'(gray8), 32'(e8 ^ (e8 >> 1)));
            check("rnd8_wrap", 32'(wrap8), 32'(w8));
            check("rnd8_dec",  32'(dec8),  32'(bin8));
            check("rnd8_onebit", 32'($countones(p8 ^ gray8)), (n8 != m8) ? 32'd1 : 32'd0);
            m4 = n4; m8 = n8;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
